// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Round-robin arbiter for a shared single-wire serial bus. It grants one node
// at a time and bounds every tenure with a timeout. After each tenure it forces
// an idle gap so that receivers can resynchronise before the next frame.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   req          in   per-node request, held high until the node is done
//   done         in   per-node one-cycle pulse on the last frame bit
//   grant        out  one-hot bus grant, registered (gates the node drivers)
//   owner        out  index of the current or last granted node
//   bus_busy     out  high while a grant is active or a gap is running
//   timeout_err  out  one-cycle pulse when a tenure is cut by the timeout
//   tenure_cnt   out  cycles elapsed in the current tenure, saturates at 127
// -----------------------------------------------------------------------------
module bus_arbiter #(
   parameter int NODES   = 4,
   parameter int OW      = 2,
   parameter int GAP     = 2,
   parameter int TIMEOUT = 96
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [NODES-1:0] req,
   input  logic [NODES-1:0] done,
   output logic [NODES-1:0] grant,
   output logic [OW-1:0]    owner,
   output logic             bus_busy,
   output logic             timeout_err,
   output logic [6:0]       tenure_cnt
);

   // The gap counter only ever holds values in 0..GAP-1.
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t          r_state;
   logic [GW-1:0]   r_gap_cnt;

   logic [OW-1:0]   w_next_owner;
   logic            w_done_own;
   logic            w_req_own;
   logic            w_timeout;
   logic            w_end;

   // Round-robin pick. Each requester gets a distance from the slot just after
   // the current owner. The nearest requester wins, so the search wraps modulo
   // NODES without needing a rotating shifter.
   function automatic logic [OW-1:0] pick_next(input logic [NODES-1:0] r,
                                                input logic [OW-1:0]    cur);
      int best_d;
      int d;
      pick_next = cur;
      best_d    = NODES;
      for (int i = 0; i < NODES; i++) begin
         d = (i + 2 * NODES - 1 - int'(cur)) % NODES;
         if (r[i] && (d < best_d)) begin
            best_d    = d;
            pick_next = OW'(i);
         end
      end
   endfunction

   // NOTE: every combinational output gets a value on every path (here by
   //       plain continuous assignment), so no latch can be inferred.
   assign w_next_owner = pick_next(req, owner);
   assign w_done_own   = done[owner];
   assign w_req_own    = req[owner];
   assign w_timeout    = (tenure_cnt == 7'(TIMEOUT - 1));
   assign w_end        = w_done_own || !w_req_own || w_timeout;

   // NOTE: sequential state uses non-blocking assignments only, so every
   //       register in this block sees pre-edge values of the others.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_gap_cnt   <= '0;
         grant       <= '0;
         owner       <= OW'(NODES - 1);   // node 0 therefore wins first
         bus_busy    <= 1'b0;
         timeout_err <= 1'b0;
         tenure_cnt  <= '0;
      end else begin
         timeout_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (|req) begin
                  grant      <= NODES'(1) << w_next_owner;
                  owner      <= w_next_owner;
                  tenure_cnt <= '0;
                  bus_busy   <= 1'b1;
                  r_state    <= S_GRANT;
               end
            end

            S_GRANT: begin
               if (tenure_cnt != 7'd127) begin
                  tenure_cnt <= tenure_cnt + 7'd1;
               end
               // Only the owner's done/req matter; a done on the same edge
               // as the timeout is a clean finish, not an error.
               if (w_end) begin
                  grant       <= '0;
                  r_gap_cnt   <= GW'(GAP - 1);
                  timeout_err <= w_timeout && !w_done_own;
                  r_state     <= S_GAP;
               end
            end

            S_GAP: begin
               // Requests are not looked at here; bus_busy drops on the edge
               // that returns to IDLE.
               if (r_gap_cnt == '0) begin
                  bus_busy <= 1'b0;
                  r_state  <= S_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt - GW'(1);
               end
            end

            default: begin
               grant   <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
